// File: rtl/enc_pkg.sv
// enc_pkg: shared constants and FSM state type for the encoding sequencer.
// Optional feature macro: ENC_DIM_PRUNE_EN (per-dimension keep/prune input).
package enc_pkg;

    localparam int DIMENSIONS    = 10000;
    localparam int WORD_W        = 32;
    localparam int LAT           = 2;
    localparam int FEATURE_COUNT = 617;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } enc_seq_state_t;

endpackage

// File: rtl/enc_dim_sequencer_if.sv
// enc_dim_sequencer_if: dimension issue bus towards the level/ID memories plus
// the query-HV word stream towards the associative memory.
// Optional feature macro: ENC_DIM_PRUNE_EN adds prune_keep.
interface enc_dim_sequencer_if #(
    parameter int DIM_IDX_W = 14,
    parameter int WORD_W    = 32
);

    logic [DIM_IDX_W-1:0] dim_idx;
    logic                 dim_valid;
    logic                 thresholded_bit;
    logic [WORD_W-1:0]    hv_word;
    logic                 hv_word_valid;
    logic                 hv_word_ready;
    logic                 hv_word_last;
`ifdef ENC_DIM_PRUNE_EN
    logic                 prune_keep;

    modport master (
        output dim_idx, dim_valid, hv_word, hv_word_valid, hv_word_last,
        input  thresholded_bit, hv_word_ready, prune_keep
    );

    modport slave (
        input  dim_idx, dim_valid, hv_word, hv_word_valid, hv_word_last,
        output thresholded_bit, hv_word_ready, prune_keep
    );
`else
    modport master (
        output dim_idx, dim_valid, hv_word, hv_word_valid, hv_word_last,
        input  thresholded_bit, hv_word_ready
    );

    modport slave (
        input  dim_idx, dim_valid, hv_word, hv_word_valid, hv_word_last,
        output thresholded_bit, hv_word_ready
    );
`endif

endinterface

// File: rtl/enc_word_buf.sv
// enc_word_buf: packs a serial bit stream into WORD_W-bit words (pack register)
// and presents them on a valid/ready output register. Knows nothing about
// dimensions: the parent says whether more bits are coming (more) or the
// stream ends with what has arrived so far (eos).
module enc_word_buf #(
    parameter int WORD_W = 32
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       bit_vld,
    input  logic                       bit_val,
    input  logic                       more,
    input  logic                       eos,
    input  logic                       out_ready,
    output logic [WORD_W-1:0]          out_word,
    output logic                       out_valid,
    output logic                       out_last,
    output logic [$clog2(WORD_W+1)-1:0] pack_cnt
);
    import enc_pkg::*;

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] pack_q, pack_d, pack_n;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_n;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              accept, move;

    // Pack the incoming bit, then decide whether the pack moves to the output
    // register. A full pack is held back only when neither more bits nor end of
    // stream is known, so that the final word can still carry last.
    always_comb begin
        pack_n = pack_q;
        cnt_n  = cnt_q;
        if (bit_vld) begin
            pack_n[cnt_q[BIT_W-1:0]] = bit_val;
            cnt_n = cnt_q + 1'b1;
        end
        accept = !valid_q || out_ready;
        move   = accept && (((cnt_n == CNT_W'(WORD_W)) && (more || eos)) ||
                            (eos && (cnt_n != '0)));
        pack_d  = pack_n;
        cnt_d   = cnt_n;
        word_d  = word_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
            word_d  = '0;
            last_d  = 1'b0;
        end
        if (move) begin
            // Upper bits of a short pack are already zero: the pack is cleared on every move.
            word_d  = pack_n;
            valid_d = 1'b1;
            last_d  = eos;
            pack_d  = '0;
            cnt_d   = '0;
        end
    end

    // Pack and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pack_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            pack_q  <= pack_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_word  = word_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign pack_cnt  = cnt_q;

endmodule

// File: rtl/enc_dim_sequencer.sv
// enc_dim_sequencer: issues dimension indices, tracks the LAT-cycle return of
// thresholded bits and streams packed query-HV words downstream.
// Optional feature macro: ENC_DIM_PRUNE_EN (prune_keep skips dimensions).
module enc_dim_sequencer #(
    parameter int DIMENSIONS = enc_pkg::DIMENSIONS,
    parameter int WORD_W     = enc_pkg::WORD_W,
    parameter int LAT        = enc_pkg::LAT,
    parameter int DIM_IDX_W  = $clog2(DIMENSIONS)
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    enc_dim_sequencer_if.master bus
);
    import enc_pkg::*;

    localparam int                   CNT_W    = $clog2(WORD_W + 1);
    localparam logic [DIM_IDX_W-1:0] LAST_IDX = DIM_IDX_W'(DIMENSIONS - 1);

    enc_seq_state_t       state_q;
    logic                 busy_q, done_q;
    logic [DIM_IDX_W-1:0] idx_q, idx_d;
    logic [LAT-1:0]       pipe_q, pipe_d;
    logic [CNT_W-1:0]     inflight_q, inflight_d;
    logic [CNT_W-1:0]     remaining, pack_cnt;
    logic [CNT_W:0]       occupancy;
    logic                 keep, arrival, credit_ok, advance, dim_valid;
    logic                 more, eos, out_valid, out_last;

`ifdef ENC_DIM_PRUNE_EN
    assign keep = bus.prune_keep;
`else
    assign keep = 1'b1;
`endif

    // Issue credit and stream-end decode. Bits in the pack plus bits still in
    // flight may not exceed one word while the output register is occupied.
    always_comb begin
        arrival   = pipe_q[LAT-1];
        occupancy = {1'b0, pack_cnt} + {1'b0, inflight_q};
        credit_ok = (occupancy < (CNT_W+1)'(WORD_W)) || !out_valid;
        advance   = (state_q == RUN) && credit_ok;
        dim_valid = advance && keep;
        remaining = inflight_q - CNT_W'(arrival);
        eos       = (state_q == DRAIN) && (remaining == '0);
`ifdef ENC_DIM_PRUNE_EN
        more      = dim_valid || (remaining != '0);
`else
        more      = (state_q == RUN) || (remaining != '0);
`endif
    end

    // Issue counter, LAT delay line and in-flight count.
    always_comb begin
        idx_d = idx_q;
        if (state_q != RUN) begin
            idx_d = '0;
        end else if (advance) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        pipe_d    = '0;
        pipe_d[0] = dim_valid;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        inflight_d = inflight_q + CNT_W'(dim_valid) - CNT_W'(arrival);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx_q      <= '0;
            pipe_q     <= '0;
            inflight_q <= '0;
        end else begin
            idx_q      <= idx_d;
            pipe_q     <= pipe_d;
            inflight_q <= inflight_d;
        end
    end

    // Sequencer FSM with registered busy/done.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (advance && (idx_q == LAST_IDX)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Second term covers a query with no kept dimensions.
                    if ((out_valid && bus.hv_word_ready && out_last) ||
                        ((inflight_q == '0) && (pack_cnt == '0) && !out_valid)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    enc_word_buf #(.WORD_W(WORD_W)) u_word_buf (
        .clk       (clk),
        .nrst      (nrst),
        .bit_vld   (arrival),
        .bit_val   (bus.thresholded_bit),
        .more      (more),
        .eos       (eos),
        .out_ready (bus.hv_word_ready),
        .out_word  (bus.hv_word),
        .out_valid (out_valid),
        .out_last  (out_last),
        .pack_cnt  (pack_cnt)
    );

    assign bus.dim_idx       = idx_q;
    assign bus.dim_valid     = dim_valid;
    assign bus.hv_word_valid = out_valid;
    assign bus.hv_word_last  = out_last;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule
